// File: rtl/conv2d_stream.sv
// -----------------------------------------------------------------------------
// conv2d_stream
//   Streaming 3x3 2-D convolution over a raster-order pixel stream. A frame of
//   IMG_W x IMG_H signed pixels goes in. One saturated result comes out for
//   every window that lies fully inside the image, with no padding. That gives
//   (IMG_W-2)*(IMG_H-2) results in raster order. Each result is registered one
//   cycle after the pixel that completes its window is accepted.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   kload_valid/idx/data coefficient write, idx = 3*row + col. Taken in IDLE
//                        only, and only for idx <= 8.
//   start                begin a frame (IDLE only)
//   busy                 state != IDLE
//   in_valid/ready/data  pixel stream, valid/ready handshake
//   out_valid/ready/data result stream, valid/ready handshake
//   out_last             marks the final result of a frame
//   done                 one-cycle pulse on the handshake of the out_last beat
// -----------------------------------------------------------------------------

// One kernel tap: full-precision signed product.
module conv2d_tap #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
) (
   input  logic signed [DATA_W-1:0]        pix_i,
   input  logic signed [COEF_W-1:0]        coef_i,
   output logic signed [DATA_W+COEF_W-1:0] prod_o
);
   localparam int PW = DATA_W + COEF_W;

   // Both operands are sign-extended to the product width, so the result is exact.
   assign prod_o = PW'(pix_i) * PW'(coef_i);
endmodule

module conv2d_stream #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kload_valid,
   input  logic [3:0]        kload_idx,
   input  logic [COEF_W-1:0] kload_data,
   input  logic              start,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = DATA_W + COEF_W;
   // Nine products need at most 4 extra bits of headroom.
   localparam int AW = PW + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             col_q;
   logic [RW-1:0]             row_q;
   logic signed [COEF_W-1:0]  coef_q [9];

   // lb0_q holds row r-1 and lb1_q holds row r-2, both indexed by column.
   // win_q[i][j] is row r-2+i and column c-2+j of the window last completed.
   logic signed [DATA_W-1:0]  lb0_q [IMG_W];
   logic signed [DATA_W-1:0]  lb1_q [IMG_W];
   logic signed [DATA_W-1:0]  win_q [3][3];

   logic signed [DATA_W-1:0]  col_new [3];
   logic signed [DATA_W-1:0]  tap_pix [9];
   logic signed [PW-1:0]      prod    [9];
   logic signed [AW-1:0]      acc;
   logic signed [AW-1:0]      shifted;
   logic [OUT_W-1:0]          sat_val;

   logic                      out_valid_q, out_last_q;
   logic [OUT_W-1:0]          out_data_q;

   logic                      accept, last_px, win_ok;

   // ---------------------------------------------------------------- handshake
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign last_px   = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign win_ok    = (col_q >= CW'(2)) && (row_q >= RW'(2));
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign done      = (state_q == DRAIN) && out_valid_q && out_ready && out_last_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && last_px) state_d = DRAIN;
         DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- window taps
   // The result is formed from the window as it will look after this pixel
   // is shifted in: columns c-1 and c-2 come from win_q, and column c comes
   // straight from the line buffers and the incoming pixel.
   assign col_new[0] = lb1_q[col_q];
   assign col_new[1] = lb0_q[col_q];
   assign col_new[2] = in_data;

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         if (gj < 2) begin : g_win
            assign tap_pix[3*gi+gj] = win_q[gi][gj+1];
         end else begin : g_new
            assign tap_pix[3*gi+gj] = col_new[gi];
         end
         conv2d_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
            .pix_i  (tap_pix[3*gi+gj]),
            .coef_i (coef_q[3*gi+gj]),
            .prod_o (prod[3*gi+gj])
         );
      end
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < 9; k++) acc = acc + AW'(prod[k]);
   end

   assign shifted = acc >>> SHIFT;

   // ---------------------------------------------------------------- saturation
   if (OUT_W >= AW) begin : g_nosat
      assign sat_val = OUT_W'(shifted);
   end else begin : g_sat
      localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [AW-1:0] MINV = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
         if (shifted > MAXV)      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
         else if (shifted < MINV) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
         else                     sat_val = shifted[OUT_W-1:0];
      end
   end

   // ---------------------------------------------------------------- control state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < 9; k++) coef_q[k] <= '0;
      end else begin
         state_q <= state_d;

         if (state_q == IDLE) begin
            // A write in the same cycle as start lands before the first pixel.
            if (kload_valid && (kload_idx <= 4'd8)) coef_q[kload_idx] <= kload_data;
            if (start) begin
               col_q <= '0;
               row_q <= '0;
            end
         end

         if (accept) begin
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end

         // accept implies the output register is empty or draining this cycle,
         // so a new result never overwrites one that is still held.
         if (accept && win_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sat_val;
            out_last_q  <= last_px;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- pixel storage
   // No reset here. Stale contents only reach windows with row < 2 or col < 2,
   // and those windows never produce a result.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
            win_q[i][2] <= col_new[i];
         end
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, kload_valid, start_a, start_b, in_valid, out_ready, rnd_en;
   logic [3:0]  kload_idx;
   logic [7:0]  kload_data, in_data;
   logic        busy_a, in_ready_a, out_valid_a, out_last_a, done_a;
   logic        busy_b, in_ready_b, out_valid_b, out_last_b, done_b;
   logic [15:0] out_data_a, out_data_b;

   int checks = 0, errors = 0, da = 0, db = 0;
   logic [15:0] qa[$], qb[$], q[$];
   logic        la[$], lb[$], l[$];
   logic        stall_b = 1'b0, hold_l = 1'b0;
   logic [15:0] hold_d = '0;

   conv2d_stream #(.IMG_W(8), .IMG_H(8), .SHIFT(0)) dut_a (
      .clk(clk), .reset(reset), .kload_valid(kload_valid), .kload_idx(kload_idx),
      .kload_data(kload_data), .start(start_a), .busy(busy_a), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a), .done(done_a));

   conv2d_stream #(.IMG_W(5), .IMG_H(4), .SHIFT(4)) dut_b (
      .clk(clk), .reset(reset), .kload_valid(kload_valid), .kload_idx(kload_idx),
      .kload_data(kload_data), .start(start_b), .busy(busy_b), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_data(in_data), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b), .done(done_b));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Sink readiness: constant 1, or random per cycle.
   always @(posedge clk) begin
      #1;
      out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: records handshakes and done pulses, and checks the stall rules.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (out_valid_a && out_ready) begin qa.push_back(out_data_a); la.push_back(out_last_a); end
         if (out_valid_b && out_ready) begin qb.push_back(out_data_b); lb.push_back(out_last_b); end
         if (done_a) da++;
         if (done_b) db++;
         if (stall_b) begin
            chk("stall_valid", out_valid_b, 1);
            chk("stall_data", $signed(out_data_b), $signed(hold_d));
            chk("stall_last", out_last_b, hold_l);
         end
         if (out_valid_b && !out_ready) chk("stall_in_ready", in_ready_b, 0);
         stall_b = out_valid_b && !out_ready;
         hold_d  = out_data_b;
         hold_l  = out_last_b;
      end else begin
         stall_b = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic kload(input int idx, input int val);
      kload_valid = 1'b1; kload_idx = 4'(idx); kload_data = 8'(val);
      tick();
      kload_valid = 1'b0;
   endtask

   task automatic load_all(input int val);
      for (int i = 0; i < 9; i++) kload(i, val);
   endtask

   function automatic logic rdy(input int sel);
      return (sel != 0) ? in_ready_b : in_ready_a;
   endfunction

   function automatic logic [7:0] pixval(input int mode, input int r, input int c, input int cst);
      case (mode)
         1:       return 8'(r*8 + c);
         2:       return 8'((r*5 + c)*7 - 40);
         default: return 8'(cst);
      endcase
   endfunction

   // Reference result for the 5x4, SHIFT=4 instance with k[idx]=idx+1, pattern 2.
   function automatic int model_b(input int n);
      int r, c, s;
      r = 2 + n/3; c = 2 + n%3; s = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s += (3*i + j + 1) * int'($signed(pixval(2, r-2+i, c-2+j, 0)));
      s = s >>> 4;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic send_px(input int sel, input logic [7:0] v);
      int n;
      in_valid = 1'b1; in_data = v; n = 0;
      @(negedge clk);
      while (!rdy(sel) && n < 500) begin n++; @(negedge clk); end
      if (n >= 500) chk("px_timeout", n, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int sel, input int target);
      int n;
      n = 0;
      while (((sel != 0) ? db : da) < target && n < 3000) begin @(negedge clk); n++; end
      chk("done_wait", int'(((sel != 0) ? db : da) >= target), 1);
   endtask

   // Runs one whole frame on the selected instance, then copies its results into q/l.
   task automatic frame(input int sel, input int mode, input int cst, input bit kstart);
      int w, h, base, ones;
      w = (sel != 0) ? 5 : 8; h = (sel != 0) ? 4 : 8;
      base = (sel != 0) ? db : da;
      qa.delete(); la.delete(); qb.delete(); lb.delete();
      if (kstart) begin kload_valid = 1'b1; kload_idx = 4'd4; kload_data = 8'd1; end
      start_a = (sel == 0); start_b = (sel != 0);
      tick();
      start_a = 1'b0; start_b = 1'b0; kload_valid = 1'b0;
      chk("busy_start", (sel != 0) ? busy_b : busy_a, 1);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (mode == 1 && r*w+c == 10) begin
               kload_valid = 1'b1; kload_idx = 4'd4; kload_data = 8'd5; start_a = 1'b1;
            end
            send_px(sel, pixval(mode, r, c, cst));
            kload_valid = 1'b0; start_a = 1'b0;
            if (mode == 1 && r*w+c == 17) chk("lat_before", out_valid_a, 0);
            if (mode == 1 && r*w+c == 18) begin
               chk("lat_valid", out_valid_a, 1);
               chk("lat_data", $signed(out_data_a), 9);
            end
         end
      end
      wait_done(sel, base + 1);
      repeat (3) tick();
      chk("done_once", (sel != 0) ? db : da, base + 1);
      chk("busy_end", (sel != 0) ? busy_b : busy_a, 0);
      if (sel != 0) begin q = qb; l = lb; end else begin q = qa; l = la; end
      ones = 0;
      foreach (l[i]) if (l[i]) ones++;
      chk("last_count", ones, 1);
      if (l.size() > 0) chk("last_pos", l[l.size()-1], 1);
      else chk("last_pos", 0, 1);
   endtask

   task automatic check_const(input string tag, input int n, input int val);
      int fb; bit found;
      fb = val; found = 0;
      chk({tag, "_count"}, q.size(), n);
      foreach (q[i]) if (!found && int'($signed(q[i])) != val) begin fb = int'($signed(q[i])); found = 1; end
      chk(tag, fb, val);
   endtask

   initial begin
      int fb, ev, r, c; bit found;
      rnd_en = 1'b0; reset = 1'b0; kload_valid = 1'b0; kload_idx = '0; kload_data = '0;
      start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) tick();

      // Outputs held in reset.
      chk("rst_busy", busy_a, 0);
      chk("rst_in_ready", in_ready_a, 0);
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_data", $signed(out_data_a), 0);
      chk("rst_out_last", out_last_a, 0);
      chk("rst_done", done_a, 0);
      reset = 1'b1;
      tick();

      // All ones: 36 results of 9.
      load_all(1);
      frame(0, 0, 1, 0);
      check_const("ones", 36, 9);

      // Centre-tap kernel. The idx=12 write must be dropped. The centre write in
      // the start cycle must be used. The write and start during RUN must be ignored.
      load_all(0);
      kload(12, 50);
      frame(0, 1, 0, 1);
      chk("ident_count", q.size(), 36);
      fb = 0; ev = 0; found = 0;
      foreach (q[n]) begin
         r = 2 + n/6; c = 2 + n%6;
         if (!found && int'($signed(q[n])) != (r-1)*8 + (c-1)) begin
            fb = int'($signed(q[n])); ev = (r-1)*8 + (c-1); found = 1;
         end
      end
      chk("ident_data", fb, ev);

      // Saturation corners.
      load_all(127);
      frame(0, 0, 127, 0);
      check_const("sat_pos", 36, 32767);
      load_all(-128);
      frame(0, 0, -128, 0);
      check_const("sat_negneg", 36, 32767);
      frame(0, 0, 127, 0);
      check_const("sat_neg", 36, -32768);

      // 5x4 instance with SHIFT=4, under random back-pressure.
      rnd_en = 1'b1;
      load_all(127);
      frame(1, 0, 127, 0);
      check_const("shift4", 6, 9072);
      for (int i = 0; i < 9; i++) kload(i, i + 1);
      frame(1, 2, 0, 0);
      chk("stall_count", q.size(), 6);
      fb = 0; ev = 0; found = 0;
      foreach (q[n]) if (!found && int'($signed(q[n])) != model_b(n)) begin
         fb = int'($signed(q[n])); ev = model_b(n); found = 1;
      end
      chk("stall_data_model", fb, ev);
      rnd_en = 1'b0;
      repeat (2) tick();

      // Reset in the middle of a frame.
      load_all(1);
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int i = 0; i < 20; i++) send_px(0, 8'd1);
      chk("mid_out_valid", out_valid_a, 1);
      reset = 1'b0;
      #2;
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_out_valid", out_valid_a, 0);
      chk("mid_rst_out_data", $signed(out_data_a), 0);
      chk("mid_rst_in_ready", in_ready_a, 0);
      chk("mid_rst_out_last", out_last_a, 0);
      tick();
      reset = 1'b1;
      tick();
      frame(0, 0, 5, 0);
      check_const("post_rst_zero", 36, 0);
      load_all(1);
      frame(0, 0, 5, 0);
      check_const("reload", 36, 45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter DATA_W, 8, signed input pixel width.
REQ-002 Parameter COEF_W, 8, signed kernel coefficient width.
REQ-003 Parameter IMG_W, 8, image columns; legal range 3..1024.
REQ-004 Parameter IMG_H, 8, image rows; legal range 3..1024.
REQ-005 Parameter OUT_W, 16, signed output width.
REQ-006 Parameter SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
REQ-007 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-008 Port reset  input  1  asynchronous, active-low reset.
REQ-009 Port kload_valid / kload_idx / kload_data  input  1 / 4 / COEF_W  kernel coefficient write; idx = 3*row + col.
REQ-010 Port start  input  1  begin one frame.
REQ-011 Port busy  output  1  high from frame start until the frame completes.
REQ-012 Port in_valid / in_ready / in_data  input / output / input  1 / 1 / DATA_W  raster-order pixel stream.
REQ-013 Port out_valid / out_ready / out_data / out_last  output / input / output / output  1 / 1 / OUT_W / 1  result stream.
REQ-014 Port done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-016 IDLE->RUN on start=1; RUN->DRAIN once IMG_W*IMG_H pixels are accepted; DRAIN->IDLE on the handshake of the out_last beat, with done=1 in that same cycle.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 Kernel writes SHALL be accepted only in IDLE; writes with kload_idx>8, or writes made outside IDLE, SHALL be ignored.
REQ-019 When kload and start occur in the same IDLE cycle, the write SHALL take effect and SHALL be used for the frame.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 Pixel handshake: in_ready = (state==RUN) && (!out_valid || out_ready); a pixel is accepted when in_valid && in_ready.
REQ-022 Two line buffers of IMG_W entries plus a 3x3 window register SHALL hold the last three rows; column and row counters SHALL wrap at IMG_W-1 and IMG_H-1 respectively.
REQ-023 A result SHALL be produced for each accepted pixel at row>=2 and col>=2 (valid outputs only, no padding), giving (IMG_W-2)*(IMG_H-2) results per frame in raster order.
REQ-024 out_valid SHALL rise in the cycle after the accepting edge of the pixel that completes the window (latency 1).
REQ-025 out_data SHALL equal sat(sum(k[i][j]*p[r-2+i][c-2+j]) >>> SHIFT).
REQ-026 Products SHALL be DATA_W+COEF_W bits and the accumulator DATA_W+COEF_W+4 bits, so no intermediate overflow occurs.
REQ-027 Saturation SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 While out_valid && !out_ready, out_data and out_last SHALL hold stable and no pixel SHALL be accepted.
REQ-029 out_last SHALL be 1 only on the final result of a frame.
REQ-030 Kernel registers SHALL persist across frames until rewritten.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE; busy, in_ready, out_valid, out_last and done =0; out_data=0; counters=0; all nine coefficients=0.
REQ-032 Line buffer contents need no reset and SHALL NOT affect any output.
REQ-033 Reset mid-frame SHALL abandon the frame; the next start SHALL process a fresh frame correctly.

Verification
REQ-034 Defaults, all k=1, all pixels 1, out_ready=1 -> 36 outputs of 9, out_last on the 36th, one done pulse.
REQ-035 k[1][1]=1, others 0, pixel(r,c)=r*8+c -> output n at (r,c) equals (r+1)*8+(c+1); first output 9, last 54.
REQ-036 All k=127, all pixels 127 -> 32767 (saturated); with SHIFT=4 -> 9072; all pixels -128 with SHIFT=0 -> 32767 after the sum; k=-128 with pixels 127 -> -32768.
REQ-037 Random out_ready toggling, IMG_W=5, IMG_H=4 -> exactly 6 outputs matching the model; out_data stable while stalled; in_ready=0 during stalls.
REQ-038 Reset asserted after 20 pixels, then k reloaded and start -> all outputs 0 except after reload; kload during RUN ignored; start during RUN ignored.
